intersection_scheduler: RTL and testbench
=========================================

# intersection_scheduler

Top-level phase scheduler for a two-approach (NS/EW) signalised intersection. It sequences both car heads through green, yellow, protected-left, yellow and all-red. It grants pedestrian walk intervals on request, with a blinking clearance. It handles emergency-vehicle preemption. All timing is counted in `i_tick` pulses; outputs use the codebase's one-hot light encodings and feed the lamp drivers directly.

## Interface
- `T_GREEN`, 20: through-green duration, ticks
- `T_YELLOW`, 2: each yellow interval, ticks
- `T_LEFT`, 10: protected-left duration, ticks
- `T_ALLRED`, 2: all-red clearance, ticks
- `T_WALK`, 10: steady walk duration, ticks
- `T_BLINK`, 6: blinking walk duration, ticks; `T_WALK+T_BLINK <= T_GREEN`; all durations 1..255
- `clk` in 1: clock
- `reset_n` in 1: reset, synchronous, active-low
- `i_tick` in 1: one-cycle timebase pulse (e.g. 1 Hz)
- `i_enable` in 1: run enable
- `i_ped_req` in 2: pedestrian buttons; [0] = crosswalk parallel to NS, [1] = parallel to EW
- `i_emerg` in 1: preemption request, level
- `i_emerg_dir` in 1: 0 = NS, 1 = EW
- `o_ns_car`, `o_ew_car` out 4: RED 1000, YELLOW 0100, LEFT 0010, GREEN 0001, NONE 0000
- `o_ns_walk`, `o_ew_walk` out 2: RED 10, GREEN 01, NONE 00
- `o_phase` out 4: current state code
- `o_ped_ack` out 2: one-cycle pulse when the walk grant for that crosswalk starts

## Operation
- States: IDLE, ALLRED_A, NS_GREEN, NS_Y1, NS_LEFT, NS_Y2, ALLRED_B, EW_GREEN, EW_Y1, EW_LEFT, EW_Y2, PRE_Y, PRE_ALLRED, PRE_HOLD.
- Normal loop: ALLRED_A→NS_GREEN→NS_Y1→NS_LEFT→NS_Y2→ALLRED_B→EW_GREEN→EW_Y1→EW_LEFT→EW_Y2→ALLRED_A.
- Durations: ALLRED_x uses `T_ALLRED`, *_GREEN uses `T_GREEN`, *_Y1/*_Y2 use `T_YELLOW`, *_LEFT uses `T_LEFT`. Default loop = 72 ticks.
- Car outputs: the active direction shows GREEN/YELLOW/LEFT per its state; the other direction shows RED. All-red states show RED on both.
- Pedestrian latch: `i_ped_req[k]` sets `req[k]`, and the latch holds until served.
- Walk grant: on entry to the parallel GREEN with `req[k]=1`, the walk head shows GREEN for `T_WALK` ticks, then alternates NONE/GREEN each tick for `T_BLINK` ticks (starting NONE), then RED. At the grant, `req[k]` clears and `o_ped_ack[k]` pulses.
- Without a latched request, or in any state other than the parallel GREEN, the walk head is RED.
- Request coincident with its own grant cycle is consumed by that grant. A request arriving after GREEN entry waits for the next cycle.
- Preemption: `i_emerg` high outside preempt states.
  - If the current state is the `i_emerg_dir` GREEN, go to PRE_HOLD keeping that GREEN.
  - If the current state is a GREEN/LEFT of the other direction, go to PRE_Y (that head YELLOW, `T_YELLOW`), then PRE_ALLRED (`T_ALLRED`), then PRE_HOLD.
  - If in a yellow or all-red state, finish that state, then go to PRE_ALLRED (skipped if already all-red), then PRE_HOLD.
  - PRE_HOLD: target direction GREEN, other direction RED, both walks RED, timer frozen. Direction is latched at preempt entry.
  - On `i_emerg` low in PRE_HOLD, go to the target direction's *_Y1 and resume the normal loop.
  - Active walk grants abort to RED at preempt entry; pending `req` bits are kept.
- `i_enable` low: next cycle IDLE, all car/walk outputs NONE, `req` retained. Enable rising: IDLE→ALLRED_A.

## Timing
- Reset: state IDLE, timer 0, `req`=00, all car/walk outputs 0000/00, `o_phase`=0, `o_ped_ack`=00.
- Timer: on state entry, load duration−1. Decrement on each `i_tick`. An `i_tick` with timer==0 causes a transition on that edge, so each state lasts exactly N ticks after entry.
- Outputs are registered: they reflect the new state on the cycle after the transition edge.
- Priority per cycle: reset > `!i_enable` > preempt entry > timer expiry.
- Preempt entry is evaluated every clock, independent of `i_tick`.
- `i_emerg` toggling inside PRE_Y/PRE_ALLRED is ignored until PRE_HOLD; a low level there exits immediately.
- Reset mid-operation: all state, latches and outputs return to reset values on that edge.

## Structure
- `traffic_pkg`: car/walk encoding constants and the phase-state enum, shared with the lamp drivers.
- Sub-module `phase_timer`: 8-bit loadable down-counter with `i_tick` enable, load, freeze and a `zero` flag.
- Phase FSM, pedestrian latch/blink logic and the output registers live in `intersection_scheduler`.

## Test plan
- Reset then enable, no requests, defaults → NS GREEN 20 ticks, YELLOW 2, LEFT 10, YELLOW 2, all-red 2; EW the same; loop period 72 ticks; walks RED throughout.
- `i_ped_req`=01 during EW_GREEN → at next NS_GREEN entry `o_ped_ack`=01 for 1 cycle; `o_ns_walk` GREEN 10 ticks, NONE/GREEN alternating 6 ticks, then RED; `req` cleared.
- `i_emerg`=1, dir=0, during NS_GREEN tick 5 → PRE_HOLD with NS GREEN held; after 30 ticks release → NS_Y1 for 2 ticks, then loop resumes.
- `i_emerg`=1, dir=1, during NS_LEFT → NS YELLOW 2 ticks, all-red 2 ticks, EW GREEN held; an active walk aborts to RED.
- `i_ped_req[1]` in the same cycle as EW_GREEN entry → consumed, ack pulses, no repeat grant next cycle.
- `i_enable` low mid-NS_GREEN → outputs NONE next cycle; re-enable → ALLRED_A then NS_GREEN at full 20 ticks. `reset_n` low mid-preempt → all reset values on the next edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared lamp encodings and the phase-state enum for the intersection
// scheduler and the lamp drivers.
//   CAR_*  : one-hot car head codes (RED/YELLOW/LEFT/GREEN, NONE = dark)
//   WALK_* : walk head codes (RED/GREEN, NONE = dark)
//   phase_t: scheduler state; the numeric value is what o_phase reports
// Helper functions classify states and give the normal-loop successor.
// -----------------------------------------------------------------------------
package traffic_pkg;

   localparam logic [3:0] CAR_RED    = 4'b1000;
   localparam logic [3:0] CAR_YELLOW = 4'b0100;
   localparam logic [3:0] CAR_LEFT   = 4'b0010;
   localparam logic [3:0] CAR_GREEN  = 4'b0001;
   localparam logic [3:0] CAR_NONE   = 4'b0000;

   localparam logic [1:0] WALK_RED   = 2'b10;
   localparam logic [1:0] WALK_GREEN = 2'b01;
   localparam logic [1:0] WALK_NONE  = 2'b00;

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_ALLRED_A   = 4'd1,
      ST_NS_GREEN   = 4'd2,
      ST_NS_Y1      = 4'd3,
      ST_NS_LEFT    = 4'd4,
      ST_NS_Y2      = 4'd5,
      ST_ALLRED_B   = 4'd6,
      ST_EW_GREEN   = 4'd7,
      ST_EW_Y1      = 4'd8,
      ST_EW_LEFT    = 4'd9,
      ST_EW_Y2      = 4'd10,
      ST_PRE_Y      = 4'd11,
      ST_PRE_ALLRED = 4'd12,
      ST_PRE_HOLD   = 4'd13
   } phase_t;

   // States in which some car head is moving traffic (green or left arrow).
   function automatic logic is_green_or_left(input phase_t s);
      return (s == ST_NS_GREEN) || (s == ST_NS_LEFT) ||
             (s == ST_EW_GREEN) || (s == ST_EW_LEFT);
   endfunction

   function automatic logic is_allred(input phase_t s);
      return (s == ST_ALLRED_A) || (s == ST_ALLRED_B);
   endfunction

   // Direction owning a normal-loop state: 0 = NS, 1 = EW.
   function automatic logic phase_dir(input phase_t s);
      return (s == ST_EW_GREEN) || (s == ST_EW_Y1) ||
             (s == ST_EW_LEFT)  || (s == ST_EW_Y2);
   endfunction

   function automatic phase_t green_of(input logic dir);
      return dir ? ST_EW_GREEN : ST_NS_GREEN;
   endfunction

   // Successor in the normal 10-state loop.
   function automatic phase_t loop_next(input phase_t s);
      phase_t n;
      case (s)
         ST_ALLRED_A: n = ST_NS_GREEN;
         ST_NS_GREEN: n = ST_NS_Y1;
         ST_NS_Y1:    n = ST_NS_LEFT;
         ST_NS_LEFT:  n = ST_NS_Y2;
         ST_NS_Y2:    n = ST_ALLRED_B;
         ST_ALLRED_B: n = ST_EW_GREEN;
         ST_EW_GREEN: n = ST_EW_Y1;
         ST_EW_Y1:    n = ST_EW_LEFT;
         ST_EW_LEFT:  n = ST_EW_Y2;
         default:     n = ST_ALLRED_A;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// 8-bit loadable down-counter used to time each scheduler phase.
//   clk, reset_n     : clock, synchronous active-low reset (count -> 0)
//   i_tick           : decrement enable (timebase pulse)
//   i_load/i_load_val: load a new count; load wins over tick
//   i_freeze         : hold the count regardless of i_tick
//   o_count_next     : value the counter takes at the next edge, so the
//                      owner can register outputs aligned with the state
//   o_zero           : current count is zero
// The counter saturates at zero; the owner reloads it on expiry.
// -----------------------------------------------------------------------------
module phase_timer (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_tick,
   input  logic       i_load,
   input  logic [7:0] i_load_val,
   input  logic       i_freeze,
   output logic [7:0] o_count_next,
   output logic       o_zero
);

   logic [7:0] r_count;

   always_comb begin
      o_count_next = r_count;
      if (i_load) begin
         o_count_next = i_load_val;
      end else if (i_tick && !i_freeze && (r_count != 8'd0)) begin
         o_count_next = r_count - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_count <= 8'd0;
      end else begin
         r_count <= o_count_next;
      end
   end

   assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/intersection_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_scheduler
// Phase scheduler for a two-approach (NS/EW) intersection: normal green /
// yellow / left / yellow / all-red loop, pedestrian walk grants with a
// blinking clearance, and emergency-vehicle preemption.
//   clk, reset_n         : clock, synchronous active-low reset
//   i_tick               : timebase pulse; all durations count these
//   i_enable             : run enable; low forces IDLE with dark lamps
//   i_ped_req[1:0]       : walk buttons, [0] parallel to NS, [1] parallel to EW
//   i_emerg, i_emerg_dir : preemption request level and target (0 NS, 1 EW)
//   o_ns_car, o_ew_car   : one-hot car heads (CAR_* codes)
//   o_ns_walk, o_ew_walk : walk heads (WALK_* codes)
//   o_phase              : current phase_t value
//   o_ped_ack[1:0]       : one-cycle pulse when a walk grant starts
// All outputs are registered from next-state values, so they change on the
// same edge as the state register.
// -----------------------------------------------------------------------------
module intersection_scheduler
   import traffic_pkg::*;
#(
   parameter int T_GREEN  = 20,
   parameter int T_YELLOW = 2,
   parameter int T_LEFT   = 10,
   parameter int T_ALLRED = 2,
   parameter int T_WALK   = 10,
   parameter int T_BLINK  = 6
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_tick,
   input  logic       i_enable,
   input  logic [1:0] i_ped_req,
   input  logic       i_emerg,
   input  logic       i_emerg_dir,
   output logic [3:0] o_ns_car,
   output logic [3:0] o_ew_car,
   output logic [1:0] o_ns_walk,
   output logic [1:0] o_ew_walk,
   output logic [3:0] o_phase,
   output logic [1:0] o_ped_ack
);

   // Timer load values: a state of N ticks starts at N-1 and ends on the
   // tick that finds the counter at zero.
   localparam logic [7:0] LD_GREEN  = 8'(T_GREEN - 1);
   localparam logic [7:0] LD_YELLOW = 8'(T_YELLOW - 1);
   localparam logic [7:0] LD_LEFT   = 8'(T_LEFT - 1);
   localparam logic [7:0] LD_ALLRED = 8'(T_ALLRED - 1);
   localparam logic [7:0] WALK_END  = 8'(T_WALK);
   localparam logic [7:0] BLINK_END = 8'(T_WALK + T_BLINK);

   function automatic logic [7:0] load_for(input phase_t s);
      logic [7:0] v;
      case (s)
         ST_NS_GREEN, ST_EW_GREEN:                 v = LD_GREEN;
         ST_NS_LEFT, ST_EW_LEFT:                   v = LD_LEFT;
         ST_ALLRED_A, ST_ALLRED_B, ST_PRE_ALLRED:  v = LD_ALLRED;
         default:                                  v = LD_YELLOW;
      endcase
      return v;
   endfunction

   // Walk head during the parallel green. Elapsed ticks are recovered from
   // the green timer, so no second counter is needed.
   function automatic logic [1:0] walk_head(input logic granted, input logic [7:0] cnt);
      logic [7:0] elapsed;
      logic [7:0] blink_idx;
      logic [1:0] v;
      elapsed   = LD_GREEN - cnt;
      blink_idx = elapsed - WALK_END;
      if (!granted) begin
         v = WALK_RED;
      end else if (elapsed < WALK_END) begin
         v = WALK_GREEN;
      end else if (elapsed < BLINK_END) begin
         // blink starts dark on the first clearance tick
         v = blink_idx[0] ? WALK_GREEN : WALK_NONE;
      end else begin
         v = WALK_RED;
      end
      return v;
   endfunction

   phase_t     r_state;
   phase_t     w_state_next;
   logic       r_pre_pend;
   logic       w_pre_pend_next;
   logic       r_pre_dir;
   logic       w_pre_dir_next;
   logic       r_yel_dir;
   logic       w_yel_dir_next;
   logic [1:0] r_req;
   logic [1:0] w_req_next;
   logic [1:0] w_req_eff;
   logic [1:0] r_walk;
   logic [1:0] w_walk_next;
   logic [1:0] w_grant;

   logic       w_load;
   logic [7:0] w_load_val;
   logic       w_freeze;
   logic [7:0] w_count_next;
   logic       w_zero;
   logic       w_expire;

   logic [3:0] r_ns_car;
   logic [3:0] r_ew_car;
   logic [1:0] r_ns_walk;
   logic [1:0] r_ew_walk;
   logic [1:0] r_ped_ack;
   logic [3:0] w_ns_car_next;
   logic [3:0] w_ew_car_next;
   logic [1:0] w_ns_walk_next;
   logic [1:0] w_ew_walk_next;

   assign w_expire = i_tick && w_zero;
   assign w_freeze = (r_state == ST_PRE_HOLD);

   phase_timer u_timer (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_tick       (i_tick),
      .i_load       (w_load),
      .i_load_val   (w_load_val),
      .i_freeze     (w_freeze),
      .o_count_next (w_count_next),
      .o_zero       (w_zero)
   );

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_pre_pend <= 1'b0;
         r_pre_dir  <= 1'b0;
         r_yel_dir  <= 1'b0;
         r_req      <= 2'b00;
         r_walk     <= 2'b00;
      end else begin
         r_state    <= w_state_next;
         r_pre_pend <= w_pre_pend_next;
         r_pre_dir  <= w_pre_dir_next;
         r_yel_dir  <= w_yel_dir_next;
         r_req      <= w_req_next;
         r_walk     <= w_walk_next;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      w_state_next    = r_state;
      w_load          = 1'b0;
      w_load_val      = 8'd0;
      w_pre_pend_next = r_pre_pend;
      w_pre_dir_next  = r_pre_dir;
      w_yel_dir_next  = r_yel_dir;

      if (!i_enable) begin
         w_state_next    = ST_IDLE;
         w_load          = 1'b1;
         w_pre_pend_next = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_next = ST_ALLRED_A;
               w_load       = 1'b1;
               w_load_val   = LD_ALLRED;
            end
            // i_emerg is not sampled while clearing toward the hold
            ST_PRE_Y: begin
               if (w_expire) begin
                  w_state_next = ST_PRE_ALLRED;
                  w_load       = 1'b1;
                  w_load_val   = LD_ALLRED;
               end
            end
            ST_PRE_ALLRED: begin
               if (w_expire) begin
                  w_state_next = ST_PRE_HOLD;
               end
            end
            ST_PRE_HOLD: begin
               if (!i_emerg) begin
                  w_state_next = r_pre_dir ? ST_EW_Y1 : ST_NS_Y1;
                  w_load       = 1'b1;
                  w_load_val   = LD_YELLOW;
               end
            end
            default: begin
               if (is_green_or_left(r_state)) begin
                  if (i_emerg) begin
                     w_pre_dir_next = i_emerg_dir;
                     if (r_state == green_of(i_emerg_dir)) begin
                        w_state_next = ST_PRE_HOLD;
                     end else begin
                        // the head currently moving traffic goes yellow
                        w_state_next   = ST_PRE_Y;
                        w_yel_dir_next = phase_dir(r_state);
                        w_load         = 1'b1;
                        w_load_val     = LD_YELLOW;
                     end
                  end else if (w_expire) begin
                     w_state_next = loop_next(r_state);
                     w_load       = 1'b1;
                     w_load_val   = load_for(loop_next(r_state));
                  end
               end else begin
                  // yellow / all-red: remember the request, finish the state
                  if (i_emerg && !r_pre_pend) begin
                     w_pre_pend_next = 1'b1;
                     w_pre_dir_next  = i_emerg_dir;
                  end
                  if (w_expire) begin
                     if (r_pre_pend || i_emerg) begin
                        w_pre_pend_next = 1'b0;
                        if (is_allred(r_state)) begin
                           w_state_next = ST_PRE_HOLD;
                        end else begin
                           w_state_next = ST_PRE_ALLRED;
                           w_load       = 1'b1;
                           w_load_val   = LD_ALLRED;
                        end
                     end else begin
                        w_state_next = loop_next(r_state);
                        w_load       = 1'b1;
                        w_load_val   = load_for(loop_next(r_state));
                     end
                  end
               end
            end
         endcase
      end
   end

   // ------------------------------------------------------ pedestrian latches
   // A press in the same cycle as the green entry is folded into the grant.
   always_comb begin
      w_req_eff = r_req | i_ped_req;
      w_grant   = 2'b00;
      if ((w_state_next == ST_NS_GREEN) && (r_state != ST_NS_GREEN)) begin
         w_grant[0] = w_req_eff[0];
      end
      if ((w_state_next == ST_EW_GREEN) && (r_state != ST_EW_GREEN)) begin
         w_grant[1] = w_req_eff[1];
      end
      w_req_next     = w_req_eff & ~w_grant;
      // a grant lives only while its parallel green does
      w_walk_next[0] = (w_state_next == ST_NS_GREEN) && (w_grant[0] || r_walk[0]);
      w_walk_next[1] = (w_state_next == ST_EW_GREEN) && (w_grant[1] || r_walk[1]);
   end

   // ---------------------------------------------------------- output decode
   always_comb begin
      w_ns_car_next  = CAR_RED;
      w_ew_car_next  = CAR_RED;
      w_ns_walk_next = walk_head(w_walk_next[0], w_count_next);
      w_ew_walk_next = walk_head(w_walk_next[1], w_count_next);
      case (w_state_next)
         ST_IDLE: begin
            w_ns_car_next  = CAR_NONE;
            w_ew_car_next  = CAR_NONE;
            w_ns_walk_next = WALK_NONE;
            w_ew_walk_next = WALK_NONE;
         end
         ST_NS_GREEN:         w_ns_car_next = CAR_GREEN;
         ST_NS_Y1, ST_NS_Y2:  w_ns_car_next = CAR_YELLOW;
         ST_NS_LEFT:          w_ns_car_next = CAR_LEFT;
         ST_EW_GREEN:         w_ew_car_next = CAR_GREEN;
         ST_EW_Y1, ST_EW_Y2:  w_ew_car_next = CAR_YELLOW;
         ST_EW_LEFT:          w_ew_car_next = CAR_LEFT;
         ST_PRE_Y: begin
            if (w_yel_dir_next) w_ew_car_next = CAR_YELLOW;
            else                w_ns_car_next = CAR_YELLOW;
         end
         ST_PRE_HOLD: begin
            if (w_pre_dir_next) w_ew_car_next = CAR_GREEN;
            else                w_ns_car_next = CAR_GREEN;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_ns_car  <= CAR_NONE;
         r_ew_car  <= CAR_NONE;
         r_ns_walk <= WALK_NONE;
         r_ew_walk <= WALK_NONE;
         r_ped_ack <= 2'b00;
      end else begin
         r_ns_car  <= w_ns_car_next;
         r_ew_car  <= w_ew_car_next;
         r_ns_walk <= w_ns_walk_next;
         r_ew_walk <= w_ew_walk_next;
         r_ped_ack <= w_grant;
      end
   end

   assign o_ns_car  = r_ns_car;
   assign o_ew_car  = r_ew_car;
   assign o_ns_walk = r_ns_walk;
   assign o_ew_walk = r_ew_walk;
   assign o_phase   = r_state;
   assign o_ped_ack = r_ped_ack;

endmodule

// File: tb/tb_intersection_scheduler.sv
// -----------------------------------------------------------------------------
// tb_intersection_scheduler
// Random stimulus (ticks, walk buttons, preemption episodes, enable drops,
// resets) against a tick-level reference model of the phase rules. The model
// tracks the phase name and the ticks remaining in it; outputs are derived
// from those each clock and compared with the DUT on the falling edge.
// -----------------------------------------------------------------------------
module tb_intersection_scheduler;

   localparam int T_GREEN  = 20;
   localparam int T_YELLOW = 2;
   localparam int T_LEFT   = 10;
   localparam int T_ALLRED = 2;
   localparam int T_WALK   = 10;
   localparam int T_BLINK  = 6;
   localparam int N_CYCLES = 40000;

   // phase numbers in the order the states are listed for o_phase
   localparam int P_IDLE = 0,  P_ARA  = 1,  P_NSG  = 2,  P_NSY1 = 3,  P_NSL = 4;
   localparam int P_NSY2 = 5,  P_ARB  = 6,  P_EWG  = 7,  P_EWY1 = 8,  P_EWL = 9;
   localparam int P_EWY2 = 10, P_PREY = 11, P_PREAR = 12, P_HOLD = 13;

   localparam bit [3:0] C_R = 4'b1000, C_Y = 4'b0100, C_L = 4'b0010, C_G = 4'b0001;
   localparam bit [1:0] W_R = 2'b10, W_G = 2'b01, W_N = 2'b00;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       i_tick;
   logic       i_enable;
   logic [1:0] i_ped_req;
   logic       i_emerg;
   logic       i_emerg_dir;
   logic [3:0] o_ns_car;
   logic [3:0] o_ew_car;
   logic [1:0] o_ns_walk;
   logic [1:0] o_ew_walk;
   logic [3:0] o_phase;
   logic [1:0] o_ped_ack;

   always #5 clk = ~clk;

   intersection_scheduler #(
      .T_GREEN  (T_GREEN),
      .T_YELLOW (T_YELLOW),
      .T_LEFT   (T_LEFT),
      .T_ALLRED (T_ALLRED),
      .T_WALK   (T_WALK),
      .T_BLINK  (T_BLINK)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_tick      (i_tick),
      .i_enable    (i_enable),
      .i_ped_req   (i_ped_req),
      .i_emerg     (i_emerg),
      .i_emerg_dir (i_emerg_dir),
      .o_ns_car    (o_ns_car),
      .o_ew_car    (o_ew_car),
      .o_ns_walk   (o_ns_walk),
      .o_ew_walk   (o_ew_walk),
      .o_phase     (o_phase),
      .o_ped_ack   (o_ped_ack)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // ------------------------------------------------------- reference model
   int       succ [14];
   int       dur  [14];
   int       m_phase;
   int       m_left;     // ticks still to run in this phase, N..1
   bit       m_pend;
   bit       m_pdir;
   bit       m_ydir;
   bit [1:0] m_req;
   bit [1:0] m_walk_on;
   bit [1:0] e_ack;

   function automatic bit greenish(input int p);
      return (p == P_NSG) || (p == P_NSL) || (p == P_EWG) || (p == P_EWL);
   endfunction

   function automatic bit dir_of(input int p);
      return (p >= P_EWG) && (p <= P_EWY2);
   endfunction

   function automatic bit [3:0] exp_car(input bit dir);
      bit [3:0] v;
      if (m_phase == P_IDLE)                                    v = 4'b0000;
      else if (m_phase == P_PREY)                               v = (dir == m_ydir) ? C_Y : C_R;
      else if (m_phase == P_HOLD)                               v = (dir == m_pdir) ? C_G : C_R;
      else if (m_phase == P_PREAR || m_phase == P_ARA || m_phase == P_ARB) v = C_R;
      else if (dir_of(m_phase) != dir)                          v = C_R;
      else if (m_phase == P_NSG || m_phase == P_EWG)            v = C_G;
      else if (m_phase == P_NSL || m_phase == P_EWL)            v = C_L;
      else                                                      v = C_Y;
      return v;
   endfunction

   function automatic bit [1:0] exp_walk(input int k);
      int e;
      bit [1:0] v;
      e = T_GREEN - m_left;
      if (m_phase == P_IDLE)                                    v = W_N;
      else if (m_phase != ((k == 1) ? P_EWG : P_NSG) || !m_walk_on[k]) v = W_R;
      else if (e < T_WALK)                                      v = W_G;
      else if (e < T_WALK + T_BLINK)                            v = (((e - T_WALK) % 2) == 0) ? W_N : W_G;
      else                                                      v = W_R;
      return v;
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE; m_left = 0; m_pend = 0; m_pdir = 0; m_ydir = 0;
      m_req = 2'b00; m_walk_on = 2'b00; e_ack = 2'b00;
   endtask

   task automatic model_step(input bit tick, input bit en, input bit [1:0] ped,
                             input bit emerg, input bit edir);
      int       np;
      int       nleft;
      bit [1:0] req_eff;
      bit [1:0] grant;
      np = m_phase; nleft = m_left; grant = 2'b00;
      if (!en) begin
         np = P_IDLE; nleft = 0; m_pend = 0;
      end else if (m_phase == P_IDLE) begin
         np = P_ARA; nleft = T_ALLRED;
      end else if (m_phase == P_HOLD) begin
         if (!emerg) begin np = m_pdir ? P_EWY1 : P_NSY1; nleft = T_YELLOW; end
      end else if (m_phase == P_PREY || m_phase == P_PREAR) begin
         if (tick) begin
            if (m_left == 1) begin
               np = (m_phase == P_PREY) ? P_PREAR : P_HOLD; nleft = T_ALLRED;
            end else nleft = m_left - 1;
         end
      end else if (greenish(m_phase) && emerg) begin
         m_pdir = edir;
         if (m_phase == (edir ? P_EWG : P_NSG)) np = P_HOLD;
         else begin np = P_PREY; nleft = T_YELLOW; m_ydir = dir_of(m_phase); end
      end else begin
         if (!greenish(m_phase) && emerg && !m_pend) begin m_pend = 1; m_pdir = edir; end
         if (tick) begin
            if (m_left == 1) begin
               if (m_pend) begin
                  m_pend = 0;
                  np = (m_phase == P_ARA || m_phase == P_ARB) ? P_HOLD : P_PREAR;
                  nleft = T_ALLRED;
               end else begin
                  np = succ[m_phase]; nleft = dur[np];
               end
            end else nleft = m_left - 1;
         end
      end
      req_eff = m_req | ped;
      if (np != m_phase && np == P_NSG) grant[0] = req_eff[0];
      if (np != m_phase && np == P_EWG) grant[1] = req_eff[1];
      m_req = req_eff & ~grant;
      if (grant[0]) m_walk_on[0] = 1;
      if (grant[1]) m_walk_on[1] = 1;
      if (np != P_NSG) m_walk_on[0] = 0;
      if (np != P_EWG) m_walk_on[1] = 0;
      m_phase = np; m_left = nleft; e_ack = grant;
   endtask

   // ------------------------------------------------------------- stimulus
   initial begin
      int  gap     = 0;
      int  em_cnt  = 0;
      int  en_off  = 0;
      bit  em_dir  = 0;
      bit  rst_now;
      bit  tick_now;
      int  n_grants = 0;
      int  n_holds  = 0;

      succ[P_ARA] = P_NSG;  succ[P_NSG] = P_NSY1; succ[P_NSY1] = P_NSL; succ[P_NSL] = P_NSY2;
      succ[P_NSY2] = P_ARB; succ[P_ARB] = P_EWG;  succ[P_EWG] = P_EWY1; succ[P_EWY1] = P_EWL;
      succ[P_EWL] = P_EWY2; succ[P_EWY2] = P_ARA;
      dur[P_ARA] = T_ALLRED; dur[P_ARB] = T_ALLRED; dur[P_NSG] = T_GREEN; dur[P_EWG] = T_GREEN;
      dur[P_NSY1] = T_YELLOW; dur[P_NSY2] = T_YELLOW; dur[P_EWY1] = T_YELLOW; dur[P_EWY2] = T_YELLOW;
      dur[P_NSL] = T_LEFT; dur[P_EWL] = T_LEFT;
      model_reset();

      reset_n = 1'b0; i_tick = 1'b0; i_enable = 1'b0;
      i_ped_req = 2'b00; i_emerg = 1'b0; i_emerg_dir = 1'b0;

      for (int c = 0; c < N_CYCLES; c++) begin
         cyc = c;
         // first 600 cycles: plain loop, no requests, to check default timing
         rst_now = (c < 3) || (c > 600 && $urandom_range(0, 6999) == 0);
         reset_n = !rst_now;

         if (c > 600 && en_off == 0 && $urandom_range(0, 2999) == 0)
            en_off = $urandom_range(1, 30);
         if (en_off > 0) begin i_enable = 1'b0; en_off--; end
         else i_enable = (c >= 3);

         tick_now = (gap == 0);
         if (tick_now) gap = $urandom_range(0, 3); else gap--;
         i_tick = tick_now;

         if (c > 600 && em_cnt == 0 && $urandom_range(0, 699) == 0) begin
            em_cnt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 200);
            em_dir = 1'($urandom_range(0, 1));
         end
         if (em_cnt > 0 && $urandom_range(0, 49) == 0) em_dir = ~em_dir;
         i_emerg     = (em_cnt > 0);
         i_emerg_dir = em_dir;
         if (em_cnt > 0) em_cnt--;

         i_ped_req = 2'b00;
         if (c > 600 && $urandom_range(0, 79) == 0) i_ped_req = 2'($urandom_range(1, 3));
         // aim some presses exactly at the edge that enters a green
         if (c > 600 && tick_now && m_left == 1 && !m_pend && !i_emerg &&
             (m_phase == P_ARA || m_phase == P_ARB) && $urandom_range(0, 1) == 0)
            i_ped_req = i_ped_req | ((m_phase == P_ARB) ? 2'b10 : 2'b01);

         @(posedge clk);
         if (rst_now) model_reset();
         else model_step(i_tick, i_enable, i_ped_req, i_emerg, i_emerg_dir);
         if (e_ack != 2'b00) n_grants++;
         if (m_phase == P_HOLD) n_holds++;

         @(negedge clk);
         check_value("ns_car",  8'(o_ns_car),  8'(exp_car(1'b0)));
         check_value("ew_car",  8'(o_ew_car),  8'(exp_car(1'b1)));
         check_value("ns_walk", 8'(o_ns_walk), 8'(exp_walk(0)));
         check_value("ew_walk", 8'(o_ew_walk), 8'(exp_walk(1)));
         check_value("phase",   8'(o_phase),   8'(m_phase));
         check_value("ped_ack", 8'(o_ped_ack), 8'(e_ack));
      end

      $display("info: %0d walk grants, %0d cycles in preempt hold", n_grants, n_holds);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
